jt49_bus_arb: RTL and testbench



---
 rtl/jt49_bus_arb_if.sv | 46 ++++
 rtl/jt49_bus_arb.sv | 175 +++++++++++++++++
 tb/tb_jt49_bus_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt49_bus_arb_if.sv
// Bundle of the two requester ports and the PSG register bus around jt49_bus_arb.
// The requester side (bench or system glue) uses the master modport.
// The arbiter uses the slave modport.
interface jt49_bus_arb_if;
  // Port 0 (sound CPU)
  logic       r0_valid;
  logic       r0_ready;
  logic       r0_rd;
  logic [3:0] r0_addr;
  logic [7:0] r0_din;
  logic [7:0] r0_rdata;
  logic       r0_rvalid;
  // Port 1 (music/command sequencer)
  logic       r1_valid;
  logic       r1_ready;
  logic       r1_rd;
  logic [3:0] r1_addr;
  logic [7:0] r1_din;
  logic [7:0] r1_rdata;
  logic       r1_rvalid;
  // PSG register bus
  logic [3:0] psg_addr;
  logic       psg_cs_n;
  logic       psg_wr_n;
  logic [7:0] psg_din;
  logic [7:0] psg_dout;
  logic       busy;

  modport master (
    output r0_valid, r0_rd, r0_addr, r0_din,
    input  r0_ready, r0_rdata, r0_rvalid,
    output r1_valid, r1_rd, r1_addr, r1_din,
    input  r1_ready, r1_rdata, r1_rvalid,
    input  psg_addr, psg_cs_n, psg_wr_n, psg_din, busy,
    output psg_dout
  );

  modport slave (
    input  r0_valid, r0_rd, r0_addr, r0_din,
    output r0_ready, r0_rdata, r0_rvalid,
    input  r1_valid, r1_rd, r1_addr, r1_din,
    output r1_ready, r1_rdata, r1_rvalid,
    output psg_addr, psg_cs_n, psg_wr_n, psg_din, busy,
    input  psg_dout
  );
endinterface

// File: rtl/jt49_bus_arb.sv
// Two-port round-robin arbiter and bus-cycle sequencer for the jt49 PSG register
// interface. Each access is SETUP -> (STROBE x WR_LEN -> HOLD | RDWAIT) -> GAP x GAP,
// so wr_n always rises and cs_n always idles between accesses. This lets the PSG's
// write-edge detection fire once per write.
module jt49_bus_arb #(
  parameter int unsigned WR_LEN = 2,  // 1..15
  parameter int unsigned GAP    = 1   // 1..15
) (
  input  logic          clk,
  input  logic          rst_n,
  jt49_bus_arb_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRdwait,
    StGap
  } state_e;

  localparam logic [3:0] WrCnt  = 4'(WR_LEN - 1);
  localparam logic [3:0] GapCnt = 4'(GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;    // port served last; 1 at reset so port 0 wins first
  logic       owner_q, owner_d;  // port that owns the in-flight access
  logic       rd_q, rd_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] din_q, din_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       busy_q, busy_d;
  logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic       grant0, grant1, idle, accept;

  // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = bus.r0_valid;
      grant1 = bus.r1_valid;
    end
  end

  assign idle         = (state_q == StIdle);
  assign accept       = idle && (grant0 || grant1);
  assign bus.r0_ready = idle && grant0;
  assign bus.r1_ready = idle && grant1;

  // Next-state, access latching and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    din_d     = din_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          owner_d = grant1;
          last_d  = grant1;
          rd_d    = grant1 ? bus.r1_rd   : bus.r0_rd;
          addr_d  = grant1 ? bus.r1_addr : bus.r0_addr;
          din_d   = grant1 ? bus.r1_din  : bus.r0_din;
        end
      end
      StSetup: begin
        if (rd_q) begin
          state_d = StRdwait;
        end else begin
          state_d = StStrobe;
          cnt_d   = WrCnt;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StGap;
        cnt_d   = GapCnt;
      end
      StRdwait: begin
        // PSG dout is registered, so it reflects the address set up one clock earlier.
        state_d = StGap;
        cnt_d   = GapCnt;
        if (owner_q) begin
          rdata1_d  = bus.psg_dout;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.psg_dout;
          rvalid0_d = 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus strobes are registered from the next state so they line up with the state.
    cs_n_d = (state_d == StIdle) || (state_d == StGap);
    wr_n_d = (state_d != StStrobe);
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset drops any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= 4'd0;
      din_q     <= 8'd0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      rdata0_q  <= 8'd0;
      rdata1_q  <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      busy_q    <= busy_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign bus.psg_addr  = addr_q;
  assign bus.psg_din   = din_q;
  assign bus.psg_cs_n  = cs_n_q;
  assign bus.psg_wr_n  = wr_n_q;
  assign bus.busy      = busy_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.r0_rvalid = rvalid0_q;
  assign bus.r1_rvalid = rvalid1_q;

endmodule

// File: tb/tb_jt49_bus_arb.sv
// Bench for jt49_bus_arb: a small PSG register model on the bus, and a transaction-level
// reference that derives per-cycle bus/handshake expectations from each accepted access.
// It also has a second instance with WR_LEN=5, GAP=3.
module tb_jt49_bus_arb;

  localparam int W  = 2;
  localparam int G  = 1;
  localparam int W2 = 5;
  localparam int G2 = 3;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] din;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic psg_clr;

  always #5 clk = ~clk;

  jt49_bus_arb_if bus ();
  jt49_bus_arb_if bus2 ();

  jt49_bus_arb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  jt49_bus_arb #(
    .WR_LEN (W2),
    .GAP    (G2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // ---------------- PSG register model ----------------
  function automatic logic [7:0] rmask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: rmask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: rmask = 8'h1F;
      default:                 rmask = 8'hFF;
    endcase
  endfunction

  logic [7:0] psg_regs [16];
  logic [7:0] psg_dout_q;
  logic       wr_n_prev;
  int         eg_restarts;

  // Write on the falling edge of wr_n with cs_n low; dout is registered from addr.
  always @(posedge clk) begin
    if (psg_clr) begin
      for (int i = 0; i < 16; i++) psg_regs[i] <= 8'h00;
      psg_dout_q  <= 8'h00;
      wr_n_prev   <= 1'b1;
      eg_restarts <= 0;
    end else begin
      if (!bus.psg_cs_n && !bus.psg_wr_n && wr_n_prev) begin
        psg_regs[bus.psg_addr] <= bus.psg_din;
        if (bus.psg_addr == 4'd13) eg_restarts <= eg_restarts + 1;
      end
      wr_n_prev  <= bus.psg_wr_n;
      psg_dout_q <= psg_regs[bus.psg_addr] & rmask(bus.psg_addr);
    end
  end

  assign bus.psg_dout  = psg_dout_q;
  assign bus2.psg_dout = 8'h00;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int         cyc = 0;
  logic       have_cur, cur_rd, cur_port, last_srv, m_busy;
  int         cur_t;
  logic [7:0] cur_rdexp;
  logic [3:0] exp_addr;
  logic [7:0] exp_din;
  logic [7:0] rdata_exp [2];
  logic [7:0] shadow [16];
  int         grants[$];
  logic       acc0, acc1, rand_gaps;
  req_t       q0[$], q1[$];
  int         rv0_seen, rv1_seen, rv1_k;
  logic [7:0] rv1_data;

  function automatic req_t mk(input logic rd, input logic [3:0] a, input logic [7:0] d);
    req_t r;
    r.rd   = rd;
    r.addr = a;
    r.din  = d;
    return r;
  endfunction

  task automatic model_reset();
    have_cur     = 1'b0;
    cur_t        = 0;
    cur_rd       = 1'b0;
    cur_port     = 1'b0;
    cur_rdexp    = 8'h00;
    last_srv     = 1'b1;
    m_busy       = 1'b0;
    exp_addr     = 4'd0;
    exp_din      = 8'd0;
    rdata_exp[0] = 8'd0;
    rdata_exp[1] = 8'd0;
  endtask

  // Expected behaviour in cycle cyc, derived from the offset k since the last acceptance.
  task automatic check_cycle();
    logic e_cs, e_wr, e_busy, e_rv0, e_rv1, free, g0, g1, v0, v1, rd;
    logic [3:0] a;
    logic [7:0] d;
    int k;
    e_cs = 1'b1; e_wr = 1'b1; e_busy = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0; free = 1'b1;
    k = cyc - cur_t;
    if (have_cur) begin
      if (!cur_rd) begin
        if (k < 3 + W + G) begin free = 1'b0; e_busy = 1'b1; end
        if (k >= 1 && k <= 2 + W) e_cs = 1'b0;
        if (k >= 2 && k <= 1 + W) e_wr = 1'b0;
      end else begin
        if (k < 3 + G) begin free = 1'b0; e_busy = 1'b1; end
        if (k == 1 || k == 2) e_cs = 1'b0;
        if (k == 3) begin
          if (cur_port) e_rv1 = 1'b1;
          else e_rv0 = 1'b1;
          rdata_exp[cur_port] = cur_rdexp;
        end
      end
    end
    if (bus.r0_rvalid === 1'b1) rv0_seen++;
    if (bus.r1_rvalid === 1'b1) begin
      rv1_seen++;
      rv1_data = bus.r1_rdata;
      rv1_k    = k;
    end
    check_eq("psg_cs_n", bus.psg_cs_n, e_cs);
    check_eq("psg_wr_n", bus.psg_wr_n, e_wr);
    check_eq("busy", bus.busy, e_busy);
    check_eq("psg_addr", bus.psg_addr, exp_addr);
    check_eq("psg_din", bus.psg_din, exp_din);
    check_eq("r0_rvalid", bus.r0_rvalid, e_rv0);
    check_eq("r1_rvalid", bus.r1_rvalid, e_rv1);
    check_eq("r0_rdata", bus.r0_rdata, rdata_exp[0]);
    check_eq("r1_rdata", bus.r1_rdata, rdata_exp[1]);

    v0 = bus.r0_valid;
    v1 = bus.r1_valid;
    g0 = 1'b0;
    g1 = 1'b0;
    if (free) begin
      if (v0 && v1) begin
        g0 = (last_srv == 1'b1);
        g1 = ~g0;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    check_eq("r0_ready", bus.r0_ready, g0);
    check_eq("r1_ready", bus.r1_ready, g1);
    acc0   = g0;
    acc1   = g1;
    m_busy = ~free;
    if (g0 || g1) begin
      rd = g1 ? bus.r1_rd : bus.r0_rd;
      a  = g1 ? bus.r1_addr : bus.r0_addr;
      d  = g1 ? bus.r1_din : bus.r0_din;
      have_cur = 1'b1;
      m_busy   = 1'b1;
      cur_t    = cyc;
      cur_port = g1;
      cur_rd   = rd;
      exp_addr = a;
      exp_din  = d;
      last_srv = g1;
      if (!rd) shadow[a] = d;
      else cur_rdexp = shadow[a] & rmask(a);
      grants.push_back(int'(g1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present queued requests; hold fields while waiting, optionally withdraw or idle.
  task automatic drive_port(input int p);
    logic v, acc, withdrew;
    req_t r;
    v        = (p == 0) ? bus.r0_valid : bus.r1_valid;
    acc      = (p == 0) ? acc0 : acc1;
    withdrew = 1'b0;
    if (acc) begin
      v = 1'b0;
    end else if (v && rand_gaps && $urandom_range(0, 31) == 0) begin
      v        = 1'b0;
      withdrew = 1'b1;
    end
    if (!v && !withdrew && ((p == 0) ? q0.size() : q1.size()) != 0 &&
        (!rand_gaps || $urandom_range(0, 2) != 0)) begin
      if (p == 0) r = q0.pop_front();
      else r = q1.pop_front();
      v = 1'b1;
      if (p == 0) begin
        bus.r0_rd = r.rd; bus.r0_addr = r.addr; bus.r0_din = r.din;
      end else begin
        bus.r1_rd = r.rd; bus.r1_addr = r.addr; bus.r1_din = r.din;
      end
    end
    if (p == 0) bus.r0_valid = v;
    else bus.r1_valid = v;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    tick();
    drive_port(0);
    drive_port(1);
    acc0 = 1'b0;
    acc1 = 1'b0;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.r0_valid || bus.r1_valid || m_busy) &&
           n < budget) begin
      step();
      n++;
    end
    for (int i = 0; i < 4; i++) step();
    check_eq("drained", 32'(q0.size() + q1.size() + int'(bus.r0_valid) + int'(bus.r1_valid)),
             32'd0);
  endtask

  // Assert reset asynchronously k clocks into an access issued by port 0.
  task automatic mid_reset(input logic rd, input int stop_k);
    int n;
    q0.push_back(mk(rd, 4'd2, 8'h55));
    n = 0;
    while (!(have_cur && (cyc - cur_t) == stop_k) && n < 40) begin
      step();
      n++;
    end
    check_eq("mid_reached", 32'(cyc - cur_t), 32'(stop_k));
    check_eq("pre_rst_wr_n", bus.psg_wr_n, rd);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_cs_n", bus.psg_cs_n, 1'b1);
    check_eq("rst_wr_n", bus.psg_wr_n, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_addr", bus.psg_addr, 4'd0);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  // WR_LEN=5 / GAP=3 instance: two back-to-back writes on port 0.
  task automatic dut2_test();
    logic cs_s[$], wr_s[$], bz_s[$];
    int setups[$];
    int n_acc, wr1, wr2, gap_n;
    n_acc = 0; wr1 = 0; wr2 = 0; gap_n = 0;
    bus2.r0_rd    = 1'b0;
    bus2.r0_addr  = 4'd13;
    bus2.r0_din   = 8'h05;
    bus2.r0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cs_s.push_back(bus2.psg_cs_n);
      wr_s.push_back(bus2.psg_wr_n);
      bz_s.push_back(bus2.busy);
      if (bus2.r0_valid && bus2.r0_ready) n_acc++;
      tick();
      if (n_acc == 1) bus2.r0_din = 8'h06;
      if (n_acc >= 2) bus2.r0_valid = 1'b0;
    end
    for (int i = 1; i < cs_s.size(); i++) if (cs_s[i-1] && !cs_s[i]) setups.push_back(i);
    check_eq("d2_accepts", 32'(n_acc), 32'd2);
    check_eq("d2_setups", 32'(setups.size()), 32'd2);
    if (setups.size() == 2) begin
      check_eq("d2_period", 32'(setups[1] - setups[0]), 32'(1 + 1 + W2 + 1 + G2));
      for (int i = setups[0]; i < setups[1]; i++) begin
        if (!wr_s[i]) wr1++;
        if (cs_s[i] && bz_s[i]) gap_n++;
      end
      for (int i = setups[1]; i < wr_s.size(); i++) if (!wr_s[i]) wr2++;
      check_eq("d2_wr_low_1", 32'(wr1), 32'(W2));
      check_eq("d2_wr_low_2", 32'(wr2), 32'(W2));
      check_eq("d2_gap", 32'(gap_n), 32'(G2));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int eg0;
    req_t r;
    rst_n   = 1'b0;
    psg_clr = 1'b1;
    bus.r0_valid = 1'b0; bus.r0_rd = 1'b0; bus.r0_addr = 4'd0; bus.r0_din = 8'd0;
    bus.r1_valid = 1'b0; bus.r1_rd = 1'b0; bus.r1_addr = 4'd0; bus.r1_din = 8'd0;
    bus2.r0_valid = 1'b0; bus2.r0_rd = 1'b0; bus2.r0_addr = 4'd0; bus2.r0_din = 8'd0;
    bus2.r1_valid = 1'b0; bus2.r1_rd = 1'b0; bus2.r1_addr = 4'd0; bus2.r1_din = 8'd0;
    acc0 = 1'b0; acc1 = 1'b0; rand_gaps = 1'b0;
    rv0_seen = 0; rv1_seen = 0; rv1_k = 0; rv1_data = 8'h00;
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    model_reset();
    tick();
    step();  // reset values checked by the model
    step();
    #2 rst_n = 1'b1;
    psg_clr = 1'b0;

    // Both ports contend with three writes each; fresh reset means port 0 goes first.
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 4'(i), 8'(8'h10 + i)));
      q1.push_back(mk(1'b0, 4'(i + 8), 8'(8'h20 + i)));
    end
    drive_port(0);
    drive_port(1);
    run(200);
    check_eq("grant_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < grants.size(); i++) check_eq($sformatf("grant%0d", i), grants[i], i % 2);

    // Single write to the envelope-shape register.
    eg0 = eg_restarts;
    q0.push_back(mk(1'b0, 4'hD, 8'h0E));
    run(100);
    check_eq("reg13_single", psg_regs[13], 8'h0E);
    check_eq("eg_single", 32'(eg_restarts - eg0), 32'd1);

    // Back-to-back reg13 writes from port 1.
    eg0 = eg_restarts;
    q1.push_back(mk(1'b0, 4'hD, 8'h08));
    q1.push_back(mk(1'b0, 4'hD, 8'h0C));
    run(100);
    check_eq("reg13_b2b", psg_regs[13], 8'h0C);
    check_eq("eg_b2b", 32'(eg_restarts - eg0), 32'd2);

    // Read of reg1 (4-bit readback) by port 1.
    q0.push_back(mk(1'b0, 4'h1, 8'hAB));
    run(100);
    rv0_seen = 0;
    rv1_seen = 0;
    q1.push_back(mk(1'b1, 4'h1, 8'h00));
    run(100);
    check_eq("rd_rv1_count", 32'(rv1_seen), 32'd1);
    check_eq("rd_rv1_data", rv1_data, 8'h0B);
    check_eq("rd_rv1_lat", 32'(rv1_k), 32'd3);
    check_eq("rd_rv0_quiet", 32'(rv0_seen), 32'd0);

    // Randomised mix with idle gaps and withdrawals.
    rand_gaps = 1'b1;
    for (int i = 0; i < 240; i++) begin
      r = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 1) == 1) q0.push_back(r);
      else q1.push_back(r);
    end
    run(6000);
    rand_gaps = 1'b0;
    for (int i = 0; i < 16; i++) check_eq($sformatf("reg%0d", i), psg_regs[i], shadow[i]);

    dut2_test();

    // Reset during a write strobe, then during a read wait; afterwards port 0 wins first.
    mid_reset(1'b0, 2);
    rv0_seen = 0;
    mid_reset(1'b1, 2);
    grants.delete();
    q0.push_back(mk(1'b0, 4'd4, 8'h33));
    q1.push_back(mk(1'b0, 4'd5, 8'h44));
    drive_port(0);
    drive_port(1);
    run(100);
    check_eq("post_rst_rvalid", 32'(rv0_seen), 32'd0);
    check_eq("post_rst_first", (grants.size() > 0) ? grants[0] : -1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
